// File: rtl/prog_loader.sv
// Byte-stream program loader: frames of LEN, N data bytes, CSUM are written into the
// instruction memory while the CPU is held. Optional idle timeout: PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
`ifdef PROG_LOADER_TIMEOUT_EN
    ,
    parameter int                TIMEOUT   = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t state, next_state;

    logic [ADDR_W:0]   n_len;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;
    logic [ADDR_W:0]   cnt_inc;
    logic              xfer;
    logic              in_frame;
    logic              last_byte;
    logic              can_start;
    logic              tmo;

    // Valid/ready: a byte moves on a rising edge where in_valid && in_ready are both high;
    // in_ready depends only on the state register, never on in_valid.
    assign in_frame  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign xfer      = in_valid && in_frame;
    assign sum_next  = sum + in_data;
    assign cnt_inc   = byte_cnt + (ADDR_W+1)'(1);
    assign last_byte = (cnt_inc == n_len);
    assign can_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

`ifdef PROG_LOADER_TIMEOUT_EN
    logic [15:0] idle_cnt;

    // The idle cycle that would bring the counter to TIMEOUT aborts the frame.
    assign tmo = in_frame && !xfer && (idle_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (xfer || can_start) begin
            idle_cnt <= '0;
        end else if (in_frame) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LEN;
            S_LEN:   if (xfer) next_state = S_DATA;
            S_DATA:  if (xfer && last_byte) next_state = S_CSUM;
            S_CSUM:  if (xfer) next_state = (sum_next == '0) ? S_DONE : S_ERR;
            S_DONE:  if (start) next_state = S_LEN;
            S_ERR:   if (start) next_state = S_LEN;
            default: next_state = S_IDLE;
        endcase
        if (tmo) next_state = S_ERR;
    end

    always_comb begin
        in_ready = in_frame;
        busy     = in_frame;
        cpu_hold = in_frame || (state == S_ERR);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
    end

    // Datapath: length, running checksum, byte counter and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_len    <= '0;
            sum      <= '0;
            byte_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (can_start) begin
                sum      <= '0;
                byte_cnt <= '0;
            end
            if (xfer && (state == S_LEN)) begin
                n_len <= (in_data == '0) ? (ADDR_W+1)'(2 ** DATA_W) : (ADDR_W+1)'(in_data);
                sum   <= in_data;
            end
            if (xfer && (state == S_DATA)) begin
                wr_en    <= 1'b1;
                wr_addr  <= BASE_ADDR + byte_cnt[ADDR_W-1:0];
                wr_data  <= in_data;
                sum      <= sum_next;
                byte_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (BASE_ADDR 0x00 and 0xFE) share the stream;
// a per-instance scoreboard matches every write pulse against the expected queue.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;

    logic       in_ready0, wr_en0, cpu_hold0, busy0, done0, err0;
    logic [7:0] wr_addr0, wr_data0;
    logic [8:0] byte_cnt0;
    logic       in_ready1, wr_en1, cpu_hold1, busy1, done1, err1;
    logic [7:0] wr_addr1, wr_data1;
    logic [8:0] byte_cnt1;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [7:0]  frame_buf[256];
    logic        sel = 1'b0;
    int          exp_idx = 0;

    wire rdy_s  = sel ? in_ready1 : in_ready0;
    wire wr_en_s = sel ? wr_en1 : wr_en0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00)) u0 (
        .clk(clk), .rst(rst), .start(start0), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .err(err0), .byte_cnt(byte_cnt0)
    );

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hFE)) u1 (
        .clk(clk), .rst(rst), .start(start1), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1), .byte_cnt(byte_cnt1)
    );

    // Scoreboard: every write pulse must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        logic [15:0] e;
        if (wr_en0) begin
            compared++;
            if (exp_q0.size() == 0) begin
                mismatched++;
                $display("FAIL wr0_unexpected got=%h@%h required=no write", wr_data0, wr_addr0);
            end else begin
                e = exp_q0.pop_front();
                if ({wr_addr0, wr_data0} !== e) begin
                    mismatched++;
                    $display("FAIL wr0_write got=%h@%h required=%h@%h", wr_data0, wr_addr0, e[7:0], e[15:8]);
                end
            end
        end
        if (wr_en1) begin
            compared++;
            if (exp_q1.size() == 0) begin
                mismatched++;
                $display("FAIL wr1_unexpected got=%h@%h required=no write", wr_data1, wr_addr1);
            end else begin
                e = exp_q1.pop_front();
                if ({wr_addr1, wr_data1} !== e) begin
                    mismatched++;
                    $display("FAIL wr1_write got=%h@%h required=%h@%h", wr_data1, wr_addr1, e[7:0], e[15:8]);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Drivers: all called from the negedge phase.
    task automatic do_start();
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        exp_idx = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_data, input bit gaps);
        int waitc;
        logic [7:0] base;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        waitc    = 0;
        while (!rdy_s && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!rdy_s) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout got in_ready=0 required=1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        if (is_data) begin
            base = sel ? 8'hFE : 8'h00;
            if (sel) exp_q1.push_back({8'(base + exp_idx[7:0]), b});
            else     exp_q0.push_back({8'(base + exp_idx[7:0]), b});
            exp_idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (is_data) begin
            compared++;
            if (wr_en_s !== 1'b1) begin
                mismatched++;
                $display("FAIL wr_latency got wr_en=%b required=1 one clock after accept", wr_en_s);
            end
        end
    endtask

    task automatic send_frame(input int n, input bit gaps, input bit bad);
        logic [7:0] s;
        s = 8'(n);
        for (int i = 0; i < n; i++) s = s + frame_buf[i];
        send_byte(8'(n), 1'b0, 1'b0);
        for (int i = 0; i < n; i++) send_byte(frame_buf[i], 1'b1, gaps);
        send_byte(bad ? 8'h00 : 8'(-s), 1'b0, gaps);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({in_ready0, wr_en0, cpu_hold0, busy0, done0, err0} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl0 got=%b required=000000", {in_ready0, wr_en0, cpu_hold0, busy0, done0, err0});
        end
        compared++;
        if ({wr_addr0, wr_data0, byte_cnt0} !== 25'd0) begin
            mismatched++;
            $display("FAIL reset_bus0 got addr=%h data=%h cnt=%0d required all 0", wr_addr0, wr_data0, byte_cnt0);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({in_ready1, wr_en1, cpu_hold1, busy1, done1, err1, wr_addr1, wr_data1, byte_cnt1} !== 31'd0) begin
            mismatched++;
            $display("FAIL reset_all1 got ctrl=%b cnt=%0d required all 0", {in_ready1, wr_en1, cpu_hold1, busy1, done1, err1}, byte_cnt1);
        end
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        compared++;
        if ({busy0, busy1, byte_cnt0, byte_cnt1} !== 20'd0) begin
            mismatched++;
            $display("FAIL idle_valid got busy=%b%b cnt=%0d/%0d required 0", busy0, busy1, byte_cnt0, byte_cnt1);
        end
    endtask

    task automatic test_nominal();
        sel = 1'b0;
        do_start();
        compared++;
        if ({busy0, in_ready0, cpu_hold0, byte_cnt0} !== {3'b111, 9'd0}) begin
            mismatched++;
            $display("FAIL start_len got busy/rdy/hold=%b%b%b cnt=%0d required 111 cnt=0", busy0, in_ready0, cpu_hold0, byte_cnt0);
        end
        frame_buf[0] = 8'hA1; frame_buf[1] = 8'hB2; frame_buf[2] = 8'hC3;
        send_frame(3, 1'b0, 1'b0);
        compared++;
        if ({done0, err0, cpu_hold0, busy0, in_ready0} !== 5'b10000) begin
            mismatched++;
            $display("FAIL nominal_done got done/err/hold/busy/rdy=%b required 10000", {done0, err0, cpu_hold0, busy0, in_ready0});
        end
        compared++;
        if (byte_cnt0 !== 9'd3) begin
            mismatched++;
            $display("FAIL nominal_cnt got=%0d required=3", byte_cnt0);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (done0 !== 1'b1) begin
            mismatched++;
            $display("FAIL done_held got=%b required=1", done0);
        end
    endtask

    task automatic test_bad_csum();
        sel = 1'b0;
        do_start();
        compared++;
        if ({done0, busy0, byte_cnt0} !== {2'b01, 9'd0}) begin
            mismatched++;
            $display("FAIL restart_clear got done=%b busy=%b cnt=%0d required done=0 busy=1 cnt=0", done0, busy0, byte_cnt0);
        end
        frame_buf[0] = 8'hA1; frame_buf[1] = 8'hB2; frame_buf[2] = 8'hC3;
        send_frame(3, 1'b0, 1'b1);
        compared++;
        if ({done0, err0, cpu_hold0, busy0, byte_cnt0} !== {4'b0110, 9'd3}) begin
            mismatched++;
            $display("FAIL bad_csum got done/err/hold/busy=%b cnt=%0d required 0110 cnt=3", {done0, err0, cpu_hold0, busy0}, byte_cnt0);
        end
        do_start();
        compared++;
        if ({err0, cpu_hold0} !== 2'b01) begin
            mismatched++;
            $display("FAIL err_clear got err=%b hold=%b required err=0 hold=1", err0, cpu_hold0);
        end
        frame_buf[0] = 8'h11; frame_buf[1] = 8'h22; frame_buf[2] = 8'h33;
        send_frame(3, 1'b0, 1'b0);
        compared++;
        if ({done0, err0} !== 2'b10) begin
            mismatched++;
            $display("FAIL reload_done got done=%b err=%b required done=1 err=0", done0, err0);
        end
    endtask

    task automatic test_wrap();
        sel = 1'b1;
        do_start();
        for (int i = 0; i < 256; i++) frame_buf[i] = 8'(i);
        send_frame(256, 1'b0, 1'b0);
        compared++;
        if ({done1, err1, byte_cnt1} !== {2'b10, 9'd256}) begin
            mismatched++;
            $display("FAIL wrap_done got done=%b err=%b cnt=%0d required done=1 err=0 cnt=256", done1, err1, byte_cnt1);
        end
        compared++;
        if (exp_q1.size() != 0) begin
            mismatched++;
            $display("FAIL wrap_drain got %0d pending writes required 0", exp_q1.size());
        end
    endtask

    task automatic test_gaps();
        sel = 1'b0;
        do_start();
        for (int i = 0; i < 12; i++) frame_buf[i] = 8'($urandom_range(0, 255));
        send_frame(12, 1'b1, 1'b0);
        compared++;
        if ({done0, err0, byte_cnt0} !== {2'b10, 9'd12}) begin
            mismatched++;
            $display("FAIL gaps_done got done=%b err=%b cnt=%0d required done=1 err=0 cnt=12", done0, err0, byte_cnt0);
        end
        compared++;
        if (exp_q0.size() != 0) begin
            mismatched++;
            $display("FAIL gaps_drain got %0d pending writes required 0", exp_q0.size());
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        do_start();
        send_byte(8'd5, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(8'h6B, 1'b1, 1'b0);
        // Third byte offered on the same edge as reset: it must not be written.
        in_data  = 8'h7C;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({in_ready0, wr_en0, done0, err0, cpu_hold0, busy0, byte_cnt0} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_mid got rdy/wr/done/err/hold/busy=%b cnt=%0d required all 0",
                     {in_ready0, wr_en0, done0, err0, cpu_hold0, busy0}, byte_cnt0);
        end
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if ({busy0, byte_cnt0} !== 10'd0) begin
            mismatched++;
            $display("FAIL reset_mid_ignore got busy=%b cnt=%0d required 0", busy0, byte_cnt0);
        end
        do_start();
        for (int i = 0; i < 5; i++) frame_buf[i] = 8'(8'h40 + i);
        send_frame(5, 1'b0, 1'b0);
        compared++;
        if ({done0, byte_cnt0} !== {1'b1, 9'd5}) begin
            mismatched++;
            $display("FAIL reset_recover got done=%b cnt=%0d required done=1 cnt=5", done0, byte_cnt0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle_valid();
        test_nominal();
        test_bad_csum();
        test_wrap();
        test_gaps();
        test_reset_mid();
        repeat (3) @(negedge clk);
        compared++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            mismatched++;
            $display("FAIL final_drain got %0d pending writes required 0", exp_q0.size() + exp_q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
